// File: rtl/regfile_scoreboard.sv
// Integer register file (2R/1W, x0 hard-wired to zero) with a per-register
// pending-write scoreboard used by the control FSM to stall operand fetch.
module regfile_scoreboard #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned READ_REG = 0,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rd1_data,
  output logic [XLEN-1:0] rd2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_addr,
  output logic            any_busy
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic             wr_en;
  logic             wr_hit1;
  logic             wr_hit2;
  logic [XLEN-1:0]  rd1_c;
  logic [XLEN-1:0]  rd2_c;

  // Write decode and same-cycle forwarding hits (x0 never matches)
  always_comb begin
    wr_en   = we && (wr_addr != '0);
    wr_hit1 = (BYPASS != 0) && wr_en && (wr_addr == rs1_addr);
    wr_hit2 = (BYPASS != 0) && wr_en && (wr_addr == rs2_addr);
  end

  // Register array: whole-array async clear, x0 never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read-side data selection: x0 reads zero, optional write forwarding
  always_comb begin
    rd1_c = '0;
    rd2_c = '0;
    if (rs1_addr != '0) begin
      rd1_c = wr_hit1 ? wr_data : regs[rs1_addr];
    end
    if (rs2_addr != '0) begin
      rd2_c = wr_hit2 ? wr_data : regs[rs2_addr];
    end
  end

  if (READ_REG != 0) begin : g_rd_reg
    logic [XLEN-1:0] rd1_q;
    logic [XLEN-1:0] rd2_q;

    // One-cycle registered read; captures the same edge's forwarded write
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd1_q <= '0;
        rd2_q <= '0;
      end else begin
        rd1_q <= rd1_c;
        rd2_q <= rd2_c;
      end
    end

    assign rd1_data = rd1_q;
    assign rd2_data = rd2_q;
  end else begin : g_rd_comb
    assign rd1_data = rd1_c;
    assign rd2_data = rd2_c;
  end

  // Scoreboard next state: writeback clears, allocation sets and wins a tie
  always_comb begin
    busy_nxt = busy_q;
    if (wr_en) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (alloc_valid && (alloc_addr != '0)) begin
      busy_nxt[alloc_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  // Source busy reports; a same-cycle writeback hides the pending bit
  always_comb begin
    rs1_busy = (rs1_addr != '0) && busy_q[rs1_addr] && !wr_hit1;
    rs2_busy = (rs2_addr != '0) && busy_q[rs2_addr] && !wr_hit2;
    any_busy = |busy_q;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard across four parameter sets.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, alloc_addr;
  logic        we, alloc_valid;
  logic [63:0] wr_data;

  logic [63:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
  logic        a_b1, a_b2, a_any, b_b1, b_b2, b_any, c_b1, c_b2, c_any;

  logic [3:0]  d_rs1_addr, d_rs2_addr, d_wr_addr, d_alloc_addr;
  logic        d_we, d_alloc_valid;
  logic [31:0] d_wr_data, d_rd1, d_rd2;
  logic        d_b1, d_b2, d_any;

  int n_cmp;
  int n_bad;

  // Default: combinational read with bypass
  regfile_scoreboard #(.XLEN(64), .NREGS(32), .READ_REG(0), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1_data(a_rd1), .rd2_data(a_rd2), .rs1_busy(a_b1), .rs2_busy(a_b2),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .any_busy(a_any));

  // Combinational read without bypass
  regfile_scoreboard #(.XLEN(64), .NREGS(32), .READ_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1_data(b_rd1), .rd2_data(b_rd2), .rs1_busy(b_b1), .rs2_busy(b_b2),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .any_busy(b_any));

  // Registered read with bypass
  regfile_scoreboard #(.XLEN(64), .NREGS(32), .READ_REG(1), .BYPASS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1_data(c_rd1), .rd2_data(c_rd2), .rs1_busy(c_b1), .rs2_busy(c_b2),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .any_busy(c_any));

  // Narrow, small configuration
  regfile_scoreboard #(.XLEN(32), .NREGS(16), .READ_REG(0), .BYPASS(1)) u_d (
    .clk(clk), .rst_n(rst_n), .rs1_addr(d_rs1_addr), .rs2_addr(d_rs2_addr),
    .rd1_data(d_rd1), .rd2_data(d_rd2), .rs1_busy(d_b1), .rs2_busy(d_b2),
    .we(d_we), .wr_addr(d_wr_addr), .wr_data(d_wr_data), .alloc_valid(d_alloc_valid),
    .alloc_addr(d_alloc_addr), .any_busy(d_any));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle;
    we = 1'b0; wr_addr = '0; wr_data = '0; alloc_valid = 1'b0; alloc_addr = '0;
    d_we = 1'b0; d_wr_addr = '0; d_wr_data = '0; d_alloc_valid = 1'b0; d_alloc_addr = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rs1_addr = '0; rs2_addr = '0; d_rs1_addr = '0; d_rs2_addr = '0;
    drive_idle();
    repeat (2) @(negedge clk);
    n_cmp++; if (a_any !== 1'b0) begin n_bad++; $display("FAIL por_any_busy: got %b want 0", a_any); end
    n_cmp++; if (c_rd1 !== 64'h0) begin n_bad++; $display("FAIL por_c_rd1: got %h want 0", c_rd1); end
    rst_n = 1'b1;
    // write reg5 and allocate reg8 before the mid-run reset
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD; alloc_valid = 1'b1; alloc_addr = 5'd8;
    @(negedge clk);
    drive_idle(); rs1_addr = 5'd5;
    #1;
    n_cmp++; if (a_rd1 !== 64'hDEAD) begin n_bad++; $display("FAIL pre_reset_rd1: got %h want dead", a_rd1); end
    n_cmp++; if (a_any !== 1'b1) begin n_bad++; $display("FAIL pre_reset_any: got %b want 1", a_any); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (a_rd1 !== 64'h0) begin n_bad++; $display("FAIL async_rst_rd1: got %h want 0", a_rd1); end
    n_cmp++; if (a_any !== 1'b0) begin n_bad++; $display("FAIL async_rst_any: got %b want 0", a_any); end
    @(negedge clk);
    rst_n = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0;
    @(posedge clk); #1;
    n_cmp++; if (a_rd1 !== 64'h0) begin n_bad++; $display("FAIL post_rst_rd1: got %h want 0", a_rd1); end
    n_cmp++; if (a_rd2 !== 64'h0) begin n_bad++; $display("FAIL post_rst_rd2: got %h want 0", a_rd2); end
    n_cmp++; if (a_b1 !== 1'b0) begin n_bad++; $display("FAIL post_rst_rs1_busy: got %b want 0", a_b1); end
    n_cmp++; if (a_any !== 1'b0) begin n_bad++; $display("FAIL post_rst_any: got %b want 0", a_any); end
    n_cmp++; if (c_rd1 !== 64'h0) begin n_bad++; $display("FAIL post_rst_c_rd1: got %h want 0", c_rd1); end
    // x0 write and allocation are ignored
    @(negedge clk);
    rs1_addr = 5'd0; we = 1'b1; wr_addr = 5'd0; wr_data = 64'h1234;
    alloc_valid = 1'b1; alloc_addr = 5'd0;
    #1;
    n_cmp++; if (a_rd1 !== 64'h0) begin n_bad++; $display("FAIL x0_bypass: got %h want 0", a_rd1); end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (a_rd1 !== 64'h0) begin n_bad++; $display("FAIL x0_read: got %h want 0", a_rd1); end
    n_cmp++; if (a_any !== 1'b0) begin n_bad++; $display("FAIL x0_alloc_any: got %b want 0", a_any); end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    rs1_addr = 5'd7; we = 1'b1; wr_addr = 5'd7; wr_data = 64'h0123_4567_89AB_CDEF;
    #1;
    n_cmp++; if (a_rd1 !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL bypass_same_cycle: got %h want 0123456789abcdef", a_rd1); end
    n_cmp++; if (b_rd1 !== 64'h0) begin n_bad++; $display("FAIL nobypass_same_cycle: got %h want 0", b_rd1); end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (b_rd1 !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL nobypass_after_edge: got %h want 0123456789abcdef", b_rd1); end
    n_cmp++; if (c_rd1 !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL regread_bypass_sample: got %h want 0123456789abcdef", c_rd1); end
  endtask

  task automatic test_regread;
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd3; wr_data = 64'hA5; rs2_addr = 5'd0;
    @(negedge clk);
    drive_idle(); rs2_addr = 5'd3;
    #1;
    n_cmp++; if (c_rd2 !== 64'h0) begin n_bad++; $display("FAIL regread_latency: got %h want 0", c_rd2); end
    @(posedge clk); #1;
    n_cmp++; if (c_rd2 !== 64'hA5) begin n_bad++; $display("FAIL regread_after_edge: got %h want a5", c_rd2); end
    @(negedge clk);
    rs2_addr = 5'd0;
    #1;
    n_cmp++; if (c_rd2 !== 64'hA5) begin n_bad++; $display("FAIL regread_hold: got %h want a5", c_rd2); end
    @(posedge clk); #1;
    n_cmp++; if (c_rd2 !== 64'h0) begin n_bad++; $display("FAIL regread_x0: got %h want 0", c_rd2); end
    @(negedge clk);
    rs2_addr = 5'd3; we = 1'b1; wr_addr = 5'd3; wr_data = 64'h5A;
    @(posedge clk); #1;
    n_cmp++; if (c_rd2 !== 64'h5A) begin n_bad++; $display("FAIL regread_same_edge_write: got %h want 5a", c_rd2); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_scoreboard;
    @(negedge clk);
    rs1_addr = 5'd9; alloc_valid = 1'b1; alloc_addr = 5'd9;
    #1;
    n_cmp++; if (a_b1 !== 1'b0) begin n_bad++; $display("FAIL alloc_same_cycle_busy: got %b want 0", a_b1); end
    n_cmp++; if (a_any !== 1'b0) begin n_bad++; $display("FAIL alloc_same_cycle_any: got %b want 0", a_any); end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (a_b1 !== 1'b1) begin n_bad++; $display("FAIL alloc_next_busy: got %b want 1", a_b1); end
    n_cmp++; if (a_any !== 1'b1) begin n_bad++; $display("FAIL alloc_next_any: got %b want 1", a_any); end
    @(negedge clk);
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd9; wr_data = 64'h99;
    #1;
    n_cmp++; if (a_b1 !== 1'b0) begin n_bad++; $display("FAIL wb_bypass_busy: got %b want 0", a_b1); end
    n_cmp++; if (b_b1 !== 1'b1) begin n_bad++; $display("FAIL wb_nobypass_busy: got %b want 1", b_b1); end
    n_cmp++; if (a_any !== 1'b1) begin n_bad++; $display("FAIL wb_any_unbypassed: got %b want 1", a_any); end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (a_b1 !== 1'b0) begin n_bad++; $display("FAIL wb_cleared_busy: got %b want 0", a_b1); end
    n_cmp++; if (a_any !== 1'b0) begin n_bad++; $display("FAIL wb_cleared_any: got %b want 0", a_any); end
  endtask

  task automatic test_simul;
    @(negedge clk);
    rs1_addr = 5'd4; rs2_addr = 5'd6;
    alloc_valid = 1'b1; alloc_addr = 5'd4; we = 1'b1; wr_addr = 5'd4; wr_data = 64'h44;
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (a_b1 !== 1'b1) begin n_bad++; $display("FAIL same_addr_set_wins: got %b want 1", a_b1); end
    n_cmp++; if (a_rd1 !== 64'h44) begin n_bad++; $display("FAIL same_addr_data: got %h want 44", a_rd1); end
    // retire reg4, then allocate reg6
    we = 1'b1; wr_addr = 5'd4; wr_data = 64'h44;
    @(negedge clk);
    drive_idle(); alloc_valid = 1'b1; alloc_addr = 5'd6;
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if ({a_b1, a_b2} !== 2'b01) begin n_bad++; $display("FAIL pre_split_busy: got %b want 01", {a_b1, a_b2}); end
    alloc_valid = 1'b1; alloc_addr = 5'd4; we = 1'b1; wr_addr = 5'd6; wr_data = 64'h66;
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if ({a_b1, a_b2} !== 2'b10) begin n_bad++; $display("FAIL split_busy: got %b want 10", {a_b1, a_b2}); end
    n_cmp++; if (a_rd2 !== 64'h66) begin n_bad++; $display("FAIL split_data: got %h want 66", a_rd2); end
    we = 1'b1; wr_addr = 5'd4; wr_data = 64'h4;
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (a_any !== 1'b0) begin n_bad++; $display("FAIL split_drain_any: got %b want 0", a_any); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd10; wr_data = 64'hAAAA_0000_0000_000A;
    @(negedge clk);
    wr_addr = 5'd11; wr_data = 64'hBBBB_0000_0000_000B;
    @(negedge clk);
    drive_idle(); rs1_addr = 5'd10; rs2_addr = 5'd11;
    #1;
    n_cmp++; if (a_rd1 !== 64'hAAAA_0000_0000_000A) begin n_bad++; $display("FAIL b2b_rd1: got %h want aaaa00000000000a", a_rd1); end
    n_cmp++; if (a_rd2 !== 64'hBBBB_0000_0000_000B) begin n_bad++; $display("FAIL b2b_rd2: got %h want bbbb00000000000b", a_rd2); end
    rs1_addr = 5'd11;
    #1;
    n_cmp++; if (a_rd1 !== a_rd2 || a_rd1 !== 64'hBBBB_0000_0000_000B) begin n_bad++; $display("FAIL same_addr_ports: got %h/%h want bbbb00000000000b", a_rd1, a_rd2); end
  endtask

  task automatic test_param;
    @(negedge clk);
    d_rs1_addr = 4'd15; d_rs2_addr = 4'd0;
    d_we = 1'b1; d_wr_addr = 4'd15; d_wr_data = 32'hFFFF_FFFF;
    d_alloc_valid = 1'b1; d_alloc_addr = 4'd15;
    #1;
    n_cmp++; if (d_rd1 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL p_bypass_rd1: got %h want ffffffff", d_rd1); end
    n_cmp++; if (d_b1 !== 1'b0) begin n_bad++; $display("FAIL p_same_cycle_busy: got %b want 0", d_b1); end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (d_rd1 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL p_rd1: got %h want ffffffff", d_rd1); end
    n_cmp++; if (d_rd2 !== 32'h0) begin n_bad++; $display("FAIL p_rd2_x0: got %h want 0", d_rd2); end
    n_cmp++; if ({d_b1, d_any} !== 2'b11) begin n_bad++; $display("FAIL p_busy_any: got %b want 11", {d_b1, d_any}); end
    d_we = 1'b1; d_wr_addr = 4'd15; d_wr_data = 32'h1;
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if ({d_b1, d_any} !== 2'b00) begin n_bad++; $display("FAIL p_cleared: got %b want 00", {d_b1, d_any}); end
    n_cmp++; if (d_rd1 !== 32'h1) begin n_bad++; $display("FAIL p_rewrite: got %h want 1", d_rd1); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_bypass();
    test_regread();
    test_scoreboard();
    test_simul();
    test_back_to_back();
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the multicycle core: NREGS x XLEN, two read ports, one write port.
- Register x0 is hard-wired to zero.
- Adds asynchronous reset of the whole array, optional write-to-read bypass, and optional registered (1-cycle) reads.
- Holds a per-register pending (busy) scoreboard. The control FSM sets a bit when it issues a destination and writeback clears it. The FSM stalls operand fetch on busy sources.

Parameters:
- XLEN, 64, data width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- AW, $clog2(NREGS), address width; derived, not overridden.
- READ_REG, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency.
- BYPASS, 1, 1 = a write in the current cycle is forwarded to reads of the same address and clears that address's busy report.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rd1_data  out  XLEN  read port 1 data.
- rd2_data  out  XLEN  read port 2 data.
- rs1_busy  out  1  rs1_addr has a pending write.
- rs2_busy  out  1  rs2_addr has a pending write.
- we  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- alloc_valid  in  1  mark alloc_addr pending.
- alloc_addr  in  AW  destination being issued.
- any_busy  out  1  OR of all busy bits, used for drain and flush checks.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle including mid-operation):
  - all registers = 0;
  - all busy bits = 0;
  - if READ_REG=1, rd1_data/rd2_data registers = 0;
  - rs*_busy = 0 and any_busy = 0.
- Reset release: the first active edge is the first rising clk with rst_n high.
- Write: on posedge, if we && wr_addr != 0, then reg[wr_addr] <= wr_data.
  - Writes to x0 are ignored.
  - A write to a non-busy register is legal: plain write, busy unchanged.
- Read, address 0: data = 0 always, both modes.
- Read, READ_REG=0: rdN_data is combinational from reg[rsN_addr].
  - If BYPASS=1, we && wr_addr == rsN_addr != 0 returns wr_data in the same cycle.
  - If BYPASS=0, the old value is returned until the edge.
- Read, READ_REG=1: rdN_data is sampled on posedge from rsN_addr, giving 1-cycle latency.
  - The sampled value includes that same edge's write when BYPASS=1, otherwise the old value.
  - Outputs hold between edges.
- Scoreboard: busy[NREGS-1:0], with busy[0] constant 0.
  - Clear on posedge when we && wr_addr != 0.
  - Set on posedge when alloc_valid && alloc_addr != 0.
  - Same address in the same cycle: set wins, so busy stays 1 (the younger allocation is outstanding).
  - Different addresses: both actions take effect.
  - Alloc of an already-busy register: stays 1, no error.
- rsN_busy (combinational):
  - BYPASS=1: busy[rsN_addr] && !(we && wr_addr == rsN_addr).
  - BYPASS=0: busy[rsN_addr].
  - Forced 0 when rsN_addr == 0.
  - Does not reflect a same-cycle alloc; that is visible next cycle.
- any_busy: OR of busy[] state, unbypassed.
- Both read ports are fully independent; identical addresses are allowed.

Test Plan:
- Reset and x0 (default params):
  - Drive rst_n low mid-run after writing reg5=0xDEAD, then release.
  - Read rs1=5, rs2=0: rd1=0, rd2=0, rs1_busy=0, any_busy=0.
  - Write x0 <= 0x1234, read x0: result 0.
- Write/read and bypass (READ_REG=0, BYPASS=1):
  - Write reg7=0x0123_4567_89AB_CDEF while rs1_addr=7: rd1 shows the new value in the same cycle.
  - Same stimulus with BYPASS=0: old value (0) until after the edge.
- Registered read (READ_REG=1):
  - With reg3=0xA5, drive rs2_addr=3 at cycle N: rd2_data=0xA5 after edge N, stable until the next edge.
  - Same-edge write of 0x5A to reg3 with BYPASS=1: sampled value is 0x5A.
- Scoreboard lifecycle:
  - alloc reg9 at cycle N: rs1_busy(9)=0 during N, 1 at N+1, any_busy=1.
  - we to reg9 at N+3: rs1_busy=0 during N+3 (bypass); busy bit clear after the edge; any_busy=0.
- Simultaneous alloc + write:
  - Same address reg4 in one cycle: busy[4]=1 after the edge and reg4 holds the written data.
  - alloc reg4 with write to reg6 in one cycle: busy4=1, busy6 cleared.
- Parametrisation (XLEN=32, NREGS=16):
  - Write reg15=0xFFFF_FFFF and alloc reg15: read returns 0xFFFF_FFFF; busy behaves per the rules above.
  - Address 0 read returns 0.
